// File: rtl/read_msg_framer_pkg.sv
// Shared types and helpers for the read-message framer: beat layout, input FSM states
// and the header-length legality check.
package read_msg_framer_pkg;

    localparam int HDR_LEN_W   = 16;
    localparam int BEAT_DATA_W = 32;

    typedef struct packed {
        logic                   last;
        logic [BEAT_DATA_W-1:0] data;
    } beat_t;

    typedef enum logic [0:0] {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    // True when a header announces a multi-word message that still fits the buffer.
    function automatic logic hdr_is_multi(input logic [HDR_LEN_W-1:0] n,
                                          input logic [31:0]          depth);
        return (n >= 16'd2) && ({16'd0, n} <= depth);
    endfunction

endpackage

// File: rtl/framer_fifo.sv
// Generic synchronous FIFO with combinational read, occupancy count and full/empty flags.
// Push while full and pop while empty are ignored.
module framer_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            rd_data_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, cleared on reset so the read port never presents stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok_s && (wr_ptr_q == AW'(i))) begin
                    mem_q[i] <= wr_data_i;
                end
            end
        end
    end

endmodule

// File: rtl/read_msg_framer.sv
// Store-and-forward framer: reassembles header-prefixed beat streams and releases a message
// only once its last beat is buffered. Optional trace: define READ_MSG_FRAMER_TRACE_EN.
module read_msg_framer
    import read_msg_framer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      in_enq__ENA,
    input  logic [DATA_W-1:0]         in_enq_v,
    input  logic [HDR_LEN_W-1:0]      in_enq_length,
    output logic                      in_enq__RDY,
    output logic                      out_enq__ENA,
    output logic [DATA_W-1:0]         out_enq_v,
    output logic                      out_enq_last,
    input  logic                      out_enq__RDY,
    output logic [$clog2(DEPTH):0]    msg_pending,
    output logic                      err_len
);

    localparam int PW = $clog2(DEPTH) + 1;

    state_e                 state_q, state_d;
    logic [HDR_LEN_W-1:0]   rem_q, rem_d;
    logic [PW-1:0]          pending_q, pending_d;
    logic                   err_q, err_d;
    logic                   wr_last_s;
    logic                   accept_s;
    logic                   pop_s;
    logic [HDR_LEN_W-1:0]   hdr_n_s;
    logic [DATA_W:0]        rd_data_s;
    logic                   rd_last_s;
    logic [PW-1:0]          fifo_count_unused_s;
    logic                   full_s;
    logic                   empty_s;

    assign in_enq__RDY  = ~full_s;
    assign accept_s     = in_enq__ENA & ~full_s;
    assign out_enq__ENA = (pending_q != '0);
    assign pop_s        = out_enq__ENA & out_enq__RDY & ~empty_s;
    assign hdr_n_s      = in_enq_v[HDR_LEN_W-1:0];
    assign rd_last_s    = rd_data_s[DATA_W];
    assign out_enq_v    = rd_data_s[DATA_W-1:0];
    assign out_enq_last = rd_last_s;
    assign msg_pending  = pending_q;
    assign err_len      = err_q;

    framer_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .push_i    (accept_s),
        .wr_data_i ({wr_last_s, in_enq_v}),
        .pop_i     (pop_s),
        .rd_data_o (rd_data_s),
        .count_o   (fifo_count_unused_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

    // Input parser: decides each beat's last flag and tracks words left in the message.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wr_last_s = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (!accept_s) begin
                    state_d = ST_HDR;
                end else if (hdr_n_s == 16'd1) begin
                    wr_last_s = 1'b1;
                end else if (hdr_is_multi(hdr_n_s, 32'(DEPTH))) begin
                    rem_d   = hdr_n_s - 16'd1;
                    state_d = ST_BODY;
                end else begin
                    // Bad length: close it as a one-word message so the consumer still sees it.
                    wr_last_s = 1'b1;
                    err_d     = 1'b1;
                end
            end
            ST_BODY: begin
                if (accept_s) begin
                    wr_last_s = (rem_q == 16'd1);
                    rem_d     = rem_q - 16'd1;
                    state_d   = (rem_q == 16'd1) ? ST_HDR : ST_BODY;
                end else begin
                    state_d = ST_BODY;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // Complete-message counter: one up per buffered last beat, one down per popped last beat.
    always_comb begin
        pending_d = pending_q;
        case ({accept_s & wr_last_s, pop_s & rd_last_s})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Parser, counter and error-pulse registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_HDR;
            rem_q     <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

`ifdef READ_MSG_FRAMER_TRACE_EN
    // Trace of accepted headers and completed messages.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            if (accept_s && (state_q == ST_HDR)) begin
                $display("framer hdr N %d length %x", hdr_n_s, in_enq_length);
            end
            if (pop_s && rd_last_s) begin
                $display("framer msg done pending %d", pending_q);
            end
        end
    end
`else
    logic len_unused_s;
    assign len_unused_s = ^in_enq_length;
`endif

endmodule
